// File: rtl/mips_pkg.sv
// Shared constants for the MIPS execute stage: ALUOp encodings, control-word
// bit positions, R-type funct codes and the multiply/divide FSM types.
package mips_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int CTL_REGDST   = 8;
  localparam int CTL_ALUSRC   = 7;
  localparam int CTL_MEMTOREG = 6;
  localparam int CTL_REGWRITE = 5;
  localparam int CTL_MEMREAD  = 4;
  localparam int CTL_MEMWRITE = 3;
  localparam int CTL_BRANCH   = 2;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic {IDLE, BUSY} md_state_t;
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per
// cycle on operand magnitudes, sign-corrected into HI/LO on the last step.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  md_op_t          i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  md_state_t         r_state;
  logic [CW-1:0]     r_count;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b, r_hi, r_lo;
  logic              r_is_div, r_neg_q, r_neg_r;

  logic              w_signed, w_is_div, w_a_neg, w_b_neg, w_div0;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_quot, w_rem;
  logic [XLEN:0]     w_sum, w_top, w_diff;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_acc_next, w_prod_fix;

  assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_is_div = (i_op == MD_DIV) || (i_op == MD_DIVU);
  assign w_a_neg  = w_signed & i_a[XLEN-1];
  assign w_b_neg  = w_signed & i_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;
  assign w_div0   = w_is_div && (i_b == '0);

  // Accumulator low half holds multiplier / dividend; r_b holds multiplicand / divisor.
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};
  assign w_top      = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff     = w_top - {1'b0, r_b};
  assign w_div_next = w_diff[XLEN] ? {w_top[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

  assign w_prod_fix = r_neg_q ? -w_acc_next : w_acc_next;
  assign w_quot     = r_neg_q ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
  assign w_rem      = r_neg_r ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          if (w_div0) begin
            r_hi <= i_a;
            r_lo <= '1;
          end else begin
            r_acc    <= {{XLEN{1'b0}}, w_a_mag};
            r_b      <= w_b_mag;
            r_count  <= '0;
            r_is_div <= w_is_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_state  <= BUSY;
          end
        end
        BUSY: if (i_abort) begin
          r_state <= IDLE;
        end else begin
          r_acc   <= w_acc_next;
          r_count <= r_count + CW'(1);
          if (r_count == CW'(MD_CYCLES - 1)) begin
            r_hi    <= r_is_div ? w_rem  : w_prod_fix[2*XLEN-1:XLEN];
            r_lo    <= r_is_div ? w_quot : w_prod_fix[XLEN-1:0];
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy = (r_state == BUSY);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: operand mux, single-cycle ALU, branch resolution and the
// EX/MEM register; multiply/divide is delegated to muldiv_unit.
module execute_stage
  import mips_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            inValid,
  input  logic            flush,
  input  logic [XLEN-1:0] register1,
  input  logic [XLEN-1:0] register2,
  input  logic [XLEN-1:0] signExtend,
  input  logic [XLEN-1:0] nextPC,
  input  logic [8:0]      controlUnitSig,
  input  logic [4:0]      rd,
  input  logic [4:0]      rt,
  input  logic [5:0]      funcBits,
  output logic            stall,
  output logic            outValid,
  output logic [XLEN-1:0] aluResult,
  output logic [XLEN-1:0] writeData,
  output logic [XLEN-1:0] branchTarget,
  output logic [4:0]      destReg,
  output logic [3:0]      memCtrl,
  output logic            PCSrc
);

  logic [XLEN-1:0] w_op_b, w_result, w_hi, w_lo;
  logic [4:0]      w_shamt;
  logic            w_known, w_is_md, w_busy, w_accept, w_load;
  md_op_t          w_md_op;

  assign w_op_b   = controlUnitSig[CTL_ALUSRC] ? signExtend : register2;
  assign w_shamt  = signExtend[10:6];
  assign stall    = w_busy;
  assign w_accept = inValid & ~flush & ~w_busy;
  assign w_load   = w_accept & ~w_is_md;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_result = '0;
    w_known  = 1'b1;
    w_is_md  = 1'b0;
    w_md_op  = MD_MULT;
    case (controlUnitSig[1:0])
      ALUOP_ADD:   w_result = register1 + w_op_b;
      ALUOP_SUB:   w_result = register1 - w_op_b;
      ALUOP_FUNCT: begin
        case (funcBits)
          F_ADD, F_ADDU: w_result = register1 + w_op_b;
          F_SUB, F_SUBU: w_result = register1 - w_op_b;
          F_AND:  w_result = register1 & w_op_b;
          F_OR:   w_result = register1 | w_op_b;
          F_XOR:  w_result = register1 ^ w_op_b;
          F_NOR:  w_result = ~(register1 | w_op_b);
          F_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(register1) < $signed(w_op_b))};
          F_SLTU: w_result = {{(XLEN-1){1'b0}}, (register1 < w_op_b)};
          F_SLL:  w_result = register2 << w_shamt;
          F_SRL:  w_result = register2 >> w_shamt;
          F_SRA:  w_result = $signed(register2) >>> w_shamt;
          F_MFHI: w_result = w_hi;
          F_MFLO: w_result = w_lo;
          F_MULT:  begin w_is_md = 1'b1; w_md_op = MD_MULT;  end
          F_MULTU: begin w_is_md = 1'b1; w_md_op = MD_MULTU; end
          F_DIV:   begin w_is_md = 1'b1; w_md_op = MD_DIV;   end
          F_DIVU:  begin w_is_md = 1'b1; w_md_op = MD_DIVU;  end
          default: w_known = 1'b0;
        endcase
      end
      default: w_known = 1'b0;
    endcase
  end

  muldiv_unit #(.XLEN(XLEN), .MD_CYCLES(MD_CYCLES)) u_muldiv (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .i_start (w_accept & w_is_md),
    .i_abort (flush),
    .i_op    (w_md_op),
    .i_a     (register1),
    .i_b     (register2),
    .o_busy  (w_busy),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  // Anything not loaded as a real ALU instruction (stall, flush, idle, mul/div) is an all-zero bubble.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      outValid     <= 1'b0;
      aluResult    <= '0;
      writeData    <= '0;
      branchTarget <= '0;
      destReg      <= '0;
      memCtrl      <= '0;
      PCSrc        <= 1'b0;
    end else if (w_load) begin
      outValid     <= 1'b1;
      aluResult    <= w_result;
      writeData    <= register2;
      branchTarget <= nextPC + (signExtend << 2);
      destReg      <= controlUnitSig[CTL_REGDST] ? rd : rt;
      memCtrl      <= {controlUnitSig[CTL_MEMTOREG], controlUnitSig[CTL_REGWRITE] & w_known,
                       controlUnitSig[CTL_MEMREAD], controlUnitSig[CTL_MEMWRITE]};
      PCSrc        <= controlUnitSig[CTL_BRANCH] & (w_result == '0);
    end else begin
      outValid     <= 1'b0;
      aluResult    <= '0;
      writeData    <= '0;
      branchTarget <= '0;
      destReg      <= '0;
      memCtrl      <= '0;
      PCSrc        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: a table of single-cycle ALU/branch vectors
// followed by hand-written mul/div, flush and reset sequences.
module tb_execute_stage;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        inValid = 1'b0, flush = 1'b0;
  logic [31:0] register1 = '0, register2 = '0, signExtend = '0, nextPC = '0;
  logic [8:0]  controlUnitSig = '0;
  logic [4:0]  rd = '0, rt = '0;
  logic [5:0]  funcBits = '0;
  logic        stall, outValid, PCSrc;
  logic [31:0] aluResult, writeData, branchTarget;
  logic [4:0]  destReg;
  logic [3:0]  memCtrl;

  int total = 0;
  int bad   = 0;

  localparam logic [8:0] C_R   = 9'h122;
  localparam logic [8:0] C_BEQ = 9'h005;
  localparam logic [8:0] C_LW  = 9'h0F0;
  localparam logic [8:0] C_SW  = 9'h088;

  execute_stage #(.XLEN(32), .MD_CYCLES(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .inValid(inValid), .flush(flush),
    .register1(register1), .register2(register2), .signExtend(signExtend), .nextPC(nextPC),
    .controlUnitSig(controlUnitSig), .rd(rd), .rt(rt), .funcBits(funcBits),
    .stall(stall), .outValid(outValid), .aluResult(aluResult), .writeData(writeData),
    .branchTarget(branchTarget), .destReg(destReg), .memCtrl(memCtrl), .PCSrc(PCSrc)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [8:0]  ctrl;
    logic [5:0]  funct;
    logic [31:0] r1, r2, se, npc;
    logic        inv, fl;
    logic [31:0] e_res;
    logic [4:0]  e_dest;
    logic [3:0]  e_mem;
    logic        e_valid, e_pc;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [8:0] c, input logic [5:0] f,
                              input logic [31:0] a, b, se, pc, input logic v, fl,
                              input logic [31:0] res, input logic [4:0] dst,
                              input logic [3:0] mem, input logic ev, epc,
                              input logic [31:0] tgt);
    vec_t t;
    t.ctrl = c; t.funct = f; t.r1 = a; t.r2 = b; t.se = se; t.npc = pc;
    t.inv = v; t.fl = fl; t.e_res = res; t.e_dest = dst; t.e_mem = mem;
    t.e_valid = ev; t.e_pc = epc; t.e_tgt = tgt;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [8:0] c, input logic [5:0] f,
                       input logic [31:0] a, b, se, pc, input logic v, fl);
    controlUnitSig = c; funcBits = f; register1 = a; register2 = b;
    signExtend = se; nextPC = pc; inValid = v; flush = fl; rd = 5'd3; rt = 5'd9;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Counts cycles with stall high from now on; a hung unit shows up as a wrong count.
  task automatic wait_idle(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      n++;
      step();
    end
    check(name, n, exp_cycles);
  endtask

  initial begin
    vec_t v;

    vecs.push_back(mk(C_R, 6'h20, 32'h7, 32'hFFFFFFFE, 0, 32'h40, 1, 0, 32'h5, 3, 4'b0100, 1, 0, 32'h40));
    vecs.push_back(mk(C_R, 6'h22, 32'h5, 32'h7, 0, 32'h40, 1, 0, 32'hFFFFFFFE, 3, 4'b0100, 1, 0, 32'h40));
    vecs.push_back(mk(C_R, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h40, 1, 0, 32'hF000F000, 3, 4'b0100, 1, 0, 32'h40));
    vecs.push_back(mk(C_R, 6'h25, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h40, 1, 0, 32'hFFF0FFF0, 3, 4'b0100, 1, 0, 32'h40));
    vecs.push_back(mk(C_R, 6'h26, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h40, 1, 0, 32'h0FF00FF0, 3, 4'b0100, 1, 0, 32'h40));
    vecs.push_back(mk(C_R, 6'h27, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h40, 1, 0, 32'h000F000F, 3, 4'b0100, 1, 0, 32'h40));
    vecs.push_back(mk(C_R, 6'h2A, 32'hFFFFFFFF, 32'h1, 0, 32'h40, 1, 0, 32'h1, 3, 4'b0100, 1, 0, 32'h40));
    vecs.push_back(mk(C_R, 6'h2B, 32'hFFFFFFFF, 32'h1, 0, 32'h40, 1, 0, 32'h0, 3, 4'b0100, 1, 0, 32'h40));
    vecs.push_back(mk(C_R, 6'h00, 32'h0, 32'h3, 32'h100, 32'h0, 1, 0, 32'h30, 3, 4'b0100, 1, 0, 32'h400));
    vecs.push_back(mk(C_R, 6'h02, 32'h0, 32'h80000000, 32'h100, 32'h0, 1, 0, 32'h08000000, 3, 4'b0100, 1, 0, 32'h400));
    vecs.push_back(mk(C_R, 6'h03, 32'h0, 32'h80000000, 32'h100, 32'h0, 1, 0, 32'hF8000000, 3, 4'b0100, 1, 0, 32'h400));
    vecs.push_back(mk(C_R, 6'h21, 32'hFFFFFFFF, 32'h2, 0, 32'h40, 1, 0, 32'h1, 3, 4'b0100, 1, 0, 32'h40));
    vecs.push_back(mk(C_R, 6'h3F, 32'h1, 32'h2, 0, 32'h40, 1, 0, 32'h0, 3, 4'b0000, 1, 0, 32'h40));
    vecs.push_back(mk(C_BEQ, 6'h00, 32'h1234, 32'h1234, 32'h4, 32'h100, 1, 0, 32'h0, 9, 4'b0000, 1, 1, 32'h110));
    vecs.push_back(mk(C_BEQ, 6'h00, 32'h1, 32'h2, 32'h4, 32'h100, 1, 0, 32'hFFFFFFFF, 9, 4'b0000, 1, 0, 32'h110));
    vecs.push_back(mk(C_LW, 6'h00, 32'h1000, 32'h0, 32'hFFFFFFFC, 32'h200, 1, 0, 32'hFFC, 9, 4'b1110, 1, 0, 32'h1F0));
    vecs.push_back(mk(C_SW, 6'h00, 32'h2000, 32'hDEADBEEF, 32'h8, 32'h300, 1, 0, 32'h2008, 9, 4'b0001, 1, 0, 32'h320));
    vecs.push_back(mk(C_R, 6'h20, 32'h7, 32'h1, 0, 32'h40, 0, 0, 32'h0, 0, 4'b0000, 0, 0, 32'h0));
    vecs.push_back(mk(C_R, 6'h20, 32'h7, 32'h1, 0, 32'h40, 1, 1, 32'h0, 0, 4'b0000, 0, 0, 32'h0));
    vecs.push_back(mk(C_BEQ, 6'h00, 32'h5, 32'h5, 32'h4, 32'h100, 1, 1, 32'h0, 0, 4'b0000, 0, 0, 32'h0));

    // Reset state
    #1;
    check("reset stall", stall, 0);
    check("reset outValid", outValid, 0);
    check("reset aluResult", aluResult, 0);
    check("reset memCtrl", memCtrl, 0);
    check("reset PCSrc", PCSrc, 0);
    check("reset branchTarget", branchTarget, 0);
    @(negedge Clk);
    Rst_n = 1'b1;

    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.ctrl, v.funct, v.r1, v.r2, v.se, v.npc, v.inv, v.fl);
      step();
      check($sformatf("v%0d aluResult", i), aluResult, v.e_res);
      check($sformatf("v%0d destReg", i), destReg, v.e_dest);
      check($sformatf("v%0d memCtrl", i), memCtrl, v.e_mem);
      check($sformatf("v%0d outValid", i), outValid, v.e_valid);
      check($sformatf("v%0d PCSrc", i), PCSrc, v.e_pc);
      check($sformatf("v%0d branchTarget", i), branchTarget, v.e_tgt);
      check($sformatf("v%0d writeData", i), writeData, v.e_valid ? v.r2 : 32'h0);
    end

    // mult -3 * 5 with mflo / mfhi held behind it
    drive(C_R, 6'h18, 32'hFFFFFFFD, 32'h5, 0, 0, 1, 0);
    step();
    check("mult outValid bubble", outValid, 0);
    drive(C_R, 6'h12, 0, 0, 0, 0, 1, 0);
    step();
    check("mult stall mid", stall, 1);
    check("mult PCSrc mid", PCSrc, 0);
    wait_idle("mult stall cycles", 31);
    step();
    check("mult mflo", aluResult, 32'hFFFFFFF1);
    check("mult mflo valid", outValid, 1);
    check("mult mflo dest", destReg, 3);
    drive(C_R, 6'h10, 0, 0, 0, 0, 1, 0);
    step();
    check("mult mfhi", aluResult, 32'hFFFFFFFF);

    // div -7 / 2
    drive(C_R, 6'h1A, 32'hFFFFFFF9, 32'h2, 0, 0, 1, 0);
    step();
    drive(C_R, 6'h12, 0, 0, 0, 0, 1, 0);
    wait_idle("div stall cycles", 32);
    step();
    check("div mflo", aluResult, 32'hFFFFFFFD);
    drive(C_R, 6'h10, 0, 0, 0, 0, 1, 0);
    step();
    check("div mfhi", aluResult, 32'hFFFFFFFF);

    // divu 9 / 0: completes in the accept cycle, no stall
    drive(C_R, 6'h1B, 32'h9, 32'h0, 0, 0, 1, 0);
    step();
    check("div0 stall", stall, 0);
    check("div0 outValid", outValid, 0);
    drive(C_R, 6'h12, 0, 0, 0, 0, 1, 0);
    step();
    check("div0 mflo", aluResult, 32'hFFFFFFFF);
    drive(C_R, 6'h10, 0, 0, 0, 0, 1, 0);
    step();
    check("div0 mfhi", aluResult, 32'h9);

    // multu 2 * 3 aborted by flush at count 10; HI/LO keep 9 / FFFFFFFF
    drive(C_R, 6'h19, 32'h2, 32'h3, 0, 0, 1, 0);
    step();
    drive(C_R, 6'h12, 0, 0, 0, 0, 1, 0);
    repeat (10) step();
    check("flush stall before", stall, 1);
    drive(C_R, 6'h12, 0, 0, 0, 0, 1, 1);
    step();
    check("flush stall after", stall, 0);
    check("flush outValid", outValid, 0);
    drive(C_R, 6'h12, 0, 0, 0, 0, 1, 0);
    step();
    check("flush mflo kept", aluResult, 32'hFFFFFFFF);
    drive(C_R, 6'h10, 0, 0, 0, 0, 1, 0);
    step();
    check("flush mfhi kept", aluResult, 32'h9);

    // Reset mid-BUSY takes effect without a clock edge
    drive(C_R, 6'h18, 32'h5, 32'h5, 0, 0, 1, 0);
    step();
    drive(C_R, 6'h12, 0, 0, 0, 0, 1, 0);
    repeat (5) step();
    check("rst pre stall", stall, 1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("rst stall", stall, 0);
    check("rst outValid", outValid, 0);
    check("rst hi", dut.u_muldiv.o_hi, 32'h0);
    check("rst lo", dut.u_muldiv.o_lo, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    drive(C_R, 6'h12, 0, 0, 0, 0, 1, 0);
    step();
    check("rst mflo", aluResult, 32'h0);
    check("rst mflo valid", outValid, 1);
    drive(C_R, 6'h10, 0, 0, 0, 0, 1, 0);
    step();
    check("rst mfhi", aluResult, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
